// File: rtl/audio_capture.sv
// audio_capture: PDM microphone receiver and 8-bit sample recorder.
//
// Divides clk_25MHZ down to the microphone clock, counts PDM ones in a fixed
// 128-bit window and reports one saturated 8-bit sample per clk_8KHZ strobe.
// While recording, samples are written to an on-chip buffer with a
// synchronous read port so the playback path can replay the take.
//
// Optional build macro: MIC_CAPTURE_LOOP_EN
//   Defined   : circular buffer, full is a sticky wrap flag, adds wr_ptr output.
//   Undefined : take stops in FULL once DEPTH samples are stored.
//
// Ports:
//   clk_25MHZ    in   system clock (single domain)
//   rst          in   synchronous active-high reset
//   clk_8KHZ     in   one-cycle sample strobe
//   mic_data     in   PDM data from the microphone
//   mic_clk      out  microphone clock
//   mic_lrsel    out  channel select, tied 0
//   record       in   level request to record
//   rd_addr      in   buffer read address
//   rd_data      out  buffer read data, 1-cycle latency
//   sample       out  most recent decimated sample
//   sample_valid out  one-cycle pulse when sample updates
//   wr_count     out  samples stored in the current take
//   recording    out  high while in RECORD
//   full         out  buffer full (sticky wrap flag in loop mode)
//   wr_ptr       out  next write address (loop mode only)
module audio_capture #(
    parameter int unsigned MIC_CLK_DIV = 12,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic              clk_25MHZ,
    input  logic              rst,
    input  logic              clk_8KHZ,
    input  logic              mic_data,
    output logic              mic_clk,
    output logic              mic_lrsel,
    input  logic              record,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [7:0]        sample,
    output logic              sample_valid,
    output logic [ADDR_W:0]   wr_count,
    output logic              recording,
    output logic              full
`ifdef MIC_CAPTURE_LOOP_EN
    ,
    output logic [ADDR_W-1:0] wr_ptr
`endif
);

    localparam int unsigned DivW = (MIC_CLK_DIV > 1) ? $clog2(MIC_CLK_DIV) : 1;
    localparam logic [DivW-1:0]   DivLast  = DivW'(MIC_CLK_DIV - 1);
    localparam logic [DivW-1:0]   DivOne   = DivW'(1);
    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StSkip, StRecord, StFull} state_e;

    // Mic clock divider
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            mic_clk_q, mic_clk_d;
    logic            div_term, bit_cap;

    assign div_term  = (div_cnt_q == DivLast);
    // Capture on the 0->1 edge so the bit is the one driven during the low phase.
    assign bit_cap   = div_term & ~mic_clk_q;
    assign div_cnt_d = div_term ? '0 : div_cnt_q + DivOne;
    assign mic_clk_d = div_term ? ~mic_clk_q : mic_clk_q;

    // Decimation window
    logic [7:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] ones_cnt_q, ones_cnt_d;
    logic [8:0] dbl;
    logic [7:0] new_sample;
    logic [7:0] sample_q, sample_d;
    logic       sample_valid_q;

    assign dbl        = {ones_cnt_q, 1'b0};
    assign new_sample = dbl[8] ? 8'hFF : dbl[7:0];
    assign sample_d   = clk_8KHZ ? new_sample : sample_q;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        if (clk_8KHZ) begin
            // A bit captured on the strobe cycle opens the new window.
            bit_cnt_d  = {7'd0, bit_cap};
            ones_cnt_d = {7'd0, bit_cap & mic_data};
        end else if (bit_cap && !bit_cnt_q[7]) begin
            bit_cnt_d  = bit_cnt_q + 8'd1;
            ones_cnt_d = ones_cnt_q + {7'd0, mic_data};
        end
    end

    // Recording FSM
    state_e          state_q, state_d;
    logic [ADDR_W:0] wr_count_q, wr_count_d;
    logic [ADDR_W-1:0] wr_addr;
    logic            we;
`ifdef MIC_CAPTURE_LOOP_EN
    localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              full_q, full_d;
    assign wr_addr = wr_ptr_q;
`else
    assign wr_addr = wr_count_q[ADDR_W-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        we         = 1'b0;
`ifdef MIC_CAPTURE_LOOP_EN
        wr_ptr_d   = wr_ptr_q;
        full_d     = full_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (record) begin
                    state_d    = StSkip;
                    wr_count_d = '0;
`ifdef MIC_CAPTURE_LOOP_EN
                    wr_ptr_d   = '0;
`endif
                end
            end
            StSkip: begin
                // First window after arming is partial; drop its sample.
                if (!record) begin
                    state_d = StIdle;
                end else if (clk_8KHZ) begin
                    state_d = StRecord;
                end
            end
            StRecord: begin
                if (!record) begin
                    state_d = StIdle;
`ifdef MIC_CAPTURE_LOOP_EN
                    full_d  = 1'b0;
`endif
                end else if (clk_8KHZ) begin
                    we = 1'b1;
`ifdef MIC_CAPTURE_LOOP_EN
                    if (wr_count_q != DepthCnt) begin
                        wr_count_d = wr_count_q + CntOne;
                    end
                    if (wr_ptr_q == PtrLast) begin
                        wr_ptr_d = '0;
                        full_d   = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PtrOne;
                    end
`else
                    wr_count_d = wr_count_q + CntOne;
                    if (wr_count_d == DepthCnt) begin
                        state_d = StFull;
                    end
`endif
                end
            end
            StFull: begin
                if (!record) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_25MHZ) begin
        if (rst) begin
            div_cnt_q      <= '0;
            mic_clk_q      <= 1'b0;
            bit_cnt_q      <= '0;
            ones_cnt_q     <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            state_q        <= StIdle;
            wr_count_q     <= '0;
`ifdef MIC_CAPTURE_LOOP_EN
            wr_ptr_q       <= '0;
            full_q         <= 1'b0;
`endif
        end else begin
            div_cnt_q      <= div_cnt_d;
            mic_clk_q      <= mic_clk_d;
            bit_cnt_q      <= bit_cnt_d;
            ones_cnt_q     <= ones_cnt_d;
            sample_q       <= sample_d;
            sample_valid_q <= clk_8KHZ;
            state_q        <= state_d;
            wr_count_q     <= wr_count_d;
`ifdef MIC_CAPTURE_LOOP_EN
            wr_ptr_q       <= wr_ptr_d;
            full_q         <= full_d;
`endif
        end
    end

    // Sample buffer; contents survive reset.
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_25MHZ) begin
        if (we && !rst) begin
            mem[wr_addr] <= new_sample;
        end
    end

    always_ff @(posedge clk_25MHZ) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign mic_clk      = mic_clk_q;
    assign mic_lrsel    = 1'b0;
    assign rd_data      = rd_data_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign wr_count     = wr_count_q;
    assign recording    = (state_q == StRecord);
`ifdef MIC_CAPTURE_LOOP_EN
    assign full         = full_q;
    assign wr_ptr       = wr_ptr_q;
`else
    assign full         = (state_q == StFull);
`endif

endmodule

// File: tb/tb_audio_capture.sv
// Directed bench for audio_capture with DEPTH=8, MIC_CLK_DIV=12.
module tb_audio_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b0;
    logic       mic_data = 1'b0;
    logic       record = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    logic       mic_clk, mic_lrsel, sample_valid, recording, full;
    logic [7:0] rd_data, sample;
    logic [3:0] wr_count;
`ifdef MIC_CAPTURE_LOOP_EN
    logic [2:0] wr_ptr;
`endif

    audio_capture #(
        .MIC_CLK_DIV(12),
        .DEPTH      (8),
        .ADDR_W     (3)
    ) dut (
        .clk_25MHZ   (clk),
        .rst         (rst),
        .clk_8KHZ    (strobe),
        .mic_data    (mic_data),
        .mic_clk     (mic_clk),
        .mic_lrsel   (mic_lrsel),
        .record      (record),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .wr_count    (wr_count),
        .recording   (recording),
        .full        (full)
`ifdef MIC_CAPTURE_LOOP_EN
        ,
        .wr_ptr      (wr_ptr)
`endif
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad = 0;
    int tick = 0;

    logic [7:0] obs_sample;
    logic       obs_valid, obs_valid2, obs_rec, obs_full;
    logic [3:0] obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            tick++;
        end
    endtask

    // Move to the negedge just after a mic_clk rising (capture) edge.
    task automatic align();
        while (((tick - 12) % 24) != 0) cyc(1);
    endtask

    // One window: strobe in the first bit period, then 'bits' captured bits.
    // mode 0: first 'ones' bits high; 1: alternating 1,0; 2: last 'ones' bits high.
    task automatic win(input int ones, input int bits, input int mode, input bit drop);
        for (int i = 0; i < bits; i++) begin
            if (mode == 1) mic_data = (i % 2 == 0);
            else if (mode == 2) mic_data = (i >= bits - ones);
            else mic_data = (i < ones);
            cyc(12);
            if (i == 0) begin
                strobe = 1'b1;
                if (drop) record = 1'b0;
                cyc(1);
                strobe     = 1'b0;
                obs_sample = sample;
                obs_valid  = sample_valid;
                obs_cnt    = wr_count;
                obs_rec    = recording;
                obs_full   = full;
                cyc(1);
                obs_valid2 = sample_valid;
                cyc(10);
            end else begin
                cyc(12);
            end
        end
        mic_data = 1'b0;
    endtask

    task automatic rd(input int a, input int exp, input string tag);
        rd_addr = 3'(a);
        cyc(1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0_exp;
        // Reset state
        cyc(3);
        chk("rst_mic_clk", mic_clk, 0);
        chk("rst_sample", sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_recording", recording, 0);
        chk("rst_full", full, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick = 0;

        // Divider: 24-cycle period, first rise 12 cycles after release
        cyc(11);
        chk("div_pre_rise", mic_clk, 0);
        chk("lrsel", mic_lrsel, 0);
        cyc(1);
        chk("div_first_rise", mic_clk, 1);
        cyc(11);
        chk("div_high", mic_clk, 1);
        cyc(1);
        chk("div_fall", mic_clk, 0);
        cyc(12);
        chk("div_second_rise", mic_clk, 1);

        // Decimation patterns
        win(130, 130, 0, 0);
        chk("win_empty", obs_sample, 0);
        chk("win_valid", obs_valid, 1);
        chk("win_valid_1cyc", obs_valid2, 0);
        win(130, 130, 0, 0);
        chk("ones_sat", obs_sample, 255);
        chk("ones_valid", obs_valid, 1);
        win(128, 130, 2, 0);
        chk("ones_sat2", obs_sample, 255);
        win(0, 130, 1, 0);
        chk("cap128", obs_sample, 252);
        win(0, 1, 0, 0);
        chk("alternating", obs_sample, 128);
        win(5, 5, 0, 0);
        chk("zeros", obs_sample, 0);
        chk("idle_no_count", obs_cnt, 0);

        // Take 1: fill the buffer
        record = 1'b1;
        cyc(1);
        chk("skip_not_rec", recording, 0);
        chk("skip_count", wr_count, 0);
        align();
        win(10, 10, 0, 0);
        chk("skip_sample", obs_sample, 10);
        chk("skip_nowrite", obs_cnt, 0);
        chk("skip_to_rec", obs_rec, 1);
        for (int k = 2; k <= 9; k++) begin
            win(5 * (k + 1), 5 * (k + 1), 0, 0);
            chk("take1_sample", obs_sample, 10 * k);
            chk("take1_count", obs_cnt, k - 1);
        end
        chk("full_flag", obs_full, 1);
`ifndef MIC_CAPTURE_LOOP_EN
        chk("full_not_rec", obs_rec, 0);
`endif
        win(0, 1, 0, 0);
        chk("tenth_sample", obs_sample, 100);
        chk("tenth_count", obs_cnt, 8);
`ifdef MIC_CAPTURE_LOOP_EN
        a0_exp = 100;
`else
        a0_exp = 20;
`endif
        rd(0, a0_exp, "take1_rd0");
        for (int a = 1; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            chk("rd_latency", rd_data, (a == 1) ? a0_exp : 10 * (a + 1));
            cyc(1);
            chk("take1_rd", rd_data, 10 * (a + 2));
        end

        // Take 2: drop record after 3 writes, on a strobe
        record = 1'b0;
        cyc(1);
        chk("drop_rec", recording, 0);
        chk("drop_full", full, 0);
        chk("drop_hold", wr_count, 8);
        record = 1'b1;
        cyc(1);
        chk("retake_clear", wr_count, 0);
        align();
        win(1, 1, 0, 0);
        win(2, 2, 0, 0);
        chk("take2_s0", obs_sample, 2);
        win(3, 3, 0, 0);
        chk("take2_s1", obs_sample, 4);
        win(1, 1, 0, 0);
        chk("take2_s2", obs_sample, 6);
        chk("take2_cnt", obs_cnt, 3);
        win(0, 1, 0, 1);
        chk("drop_strobe_sample", obs_sample, 2);
        chk("drop_strobe_valid", obs_valid, 1);
        chk("drop_strobe_cnt", obs_cnt, 3);
        chk("drop_strobe_rec", obs_rec, 0);
        rd(0, 2, "take2_rd0");
        rd(1, 4, "take2_rd1");
        rd(2, 6, "take2_rd2");
        rd(3, 50, "take2_rd3");

        // Take 3: reset after 5 writes
        record = 1'b1;
        cyc(1);
        chk("take3_clear", wr_count, 0);
        align();
        win(4, 4, 0, 0);
        win(5, 5, 0, 0);
        win(6, 6, 0, 0);
        win(7, 7, 0, 0);
        win(8, 8, 0, 0);
        win(0, 1, 0, 0);
        chk("take3_s4", obs_sample, 16);
        chk("take3_cnt", obs_cnt, 5);
        chk("take3_rec", obs_rec, 1);
        rst = 1'b1;
        record = 1'b0;
        cyc(1);
        chk("mid_rst_mic_clk", mic_clk, 0);
        chk("mid_rst_sample", sample, 0);
        chk("mid_rst_valid", sample_valid, 0);
        chk("mid_rst_count", wr_count, 0);
        chk("mid_rst_rec", recording, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_rd", rd_data, 0);
        rst = 1'b0;
        tick = 0;
        rd(0, 8, "keep_rd0");
        rd(1, 10, "keep_rd1");
        rd(2, 12, "keep_rd2");
        rd(3, 14, "keep_rd3");
        rd(4, 16, "keep_rd4");
        rd(5, 70, "keep_rd5");
        chk("post_rst_idle", recording, 0);

`ifdef MIC_CAPTURE_LOOP_EN
        // Circular buffer: 11 writes
        cyc(12);
        record = 1'b1;
        cyc(1);
        align();
        for (int i = 0; i < 12; i++) begin
            win(i + 1, i + 1, 0, 0);
        end
        chk("loop_ptr", wr_ptr, 3);
        chk("loop_full", full, 1);
        chk("loop_count", wr_count, 8);
        rd(0, 18, "loop_rd0");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
